// File: rtl/mem_march_bist_if.sv
// Single-port memory bus shared between the March C- BIST engine and the memory under test.
interface mem_march_bist_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] add;
  logic [DATA_W-1:0] data_in;
  logic              we;
  logic [DATA_W-1:0] data_out;

  modport master (output add, output data_in, output we, input data_out);
  modport slave  (input add, input data_in, input we, output data_out);
endinterface

// File: rtl/mem_march_bist.sv
// March C- self-test engine: sweeps every address with six March elements and records
// pass/fail status plus first-failure address and element.
module mem_march_bist #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [2:0]          fail_elem,
  output logic [7:0]          fail_cnt,
  mem_march_bist_if.master    mem
);

  localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [2:0] ELEM_LAST = 3'd5;

  typedef enum logic [1:0] {IDLE, RD, RWAIT, WR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [2:0]        elem, elem_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              busy_nxt, done_nxt, fail_nxt;
  logic [ADDR_W-1:0] fail_addr_nxt;
  logic [2:0]        fail_elem_nxt;
  logic [7:0]        fail_cnt_nxt;
  logic              step;
  logic              mismatch;

  // M3 and M4 walk the address space downward; all others upward.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic [DATA_W-1:0] read_exp(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  function automatic logic [DATA_W-1:0] write_pat(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  function automatic logic [ADDR_W-1:0] first_addr(input logic [2:0] e);
    return elem_down(e) ? ADDR_MAX : {ADDR_W{1'b0}};
  endfunction

  function automatic logic [ADDR_W-1:0] last_addr(input logic [2:0] e);
    return elem_down(e) ? {ADDR_W{1'b0}} : ADDR_MAX;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign mismatch = (mem.data_out != read_exp(elem));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      elem      <= '0;
      wcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      elem      <= elem_nxt;
      wcnt      <= wcnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      fail      <= fail_nxt;
      fail_addr <= fail_addr_nxt;
      fail_elem <= fail_elem_nxt;
      fail_cnt  <= fail_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    elem_nxt      = elem;
    wcnt_nxt      = wcnt;
    busy_nxt      = busy;
    done_nxt      = done;
    fail_nxt      = fail;
    fail_addr_nxt = fail_addr;
    fail_elem_nxt = fail_elem;
    fail_cnt_nxt  = fail_cnt;
    step          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = WR;
          addr_nxt      = '0;
          elem_nxt      = '0;
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          fail_nxt      = 1'b0;
          fail_addr_nxt = '0;
          fail_elem_nxt = '0;
          fail_cnt_nxt  = '0;
        end
      end
      RD: begin
        state_nxt = RWAIT;
        wcnt_nxt  = WCNT_W'(RD_LAT - 1);
      end
      RWAIT: begin
        if (wcnt != '0) begin
          wcnt_nxt = wcnt - WCNT_W'(1);
        end else begin
          // data_out is valid only in the final wait cycle
          if (mismatch) begin
            fail_nxt     = 1'b1;
            fail_cnt_nxt = sat_inc(fail_cnt);
            if (!fail) begin
              fail_addr_nxt = addr;
              fail_elem_nxt = elem;
            end
          end
          if (elem != ELEM_LAST) state_nxt = WR;
          else                   step      = 1'b1;
        end
      end
      WR:      step = 1'b1;
      default: state_nxt = IDLE;
    endcase

    // Address/element advance; the address only wraps at an element boundary.
    if (step) begin
      if (addr == last_addr(elem)) begin
        if (elem == ELEM_LAST) begin
          state_nxt = IDLE;
          addr_nxt  = '0;
          elem_nxt  = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          elem_nxt  = elem + 3'd1;
          addr_nxt  = first_addr(elem + 3'd1);
          state_nxt = RD;
        end
      end else begin
        addr_nxt  = elem_down(elem) ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        state_nxt = (elem == 3'd0) ? WR : RD;
      end
    end
  end

  assign mem.add     = addr;
  assign mem.we      = (state == WR);
  assign mem.data_in = (state == WR)   ? write_pat(elem) :
                       (state == IDLE) ? {DATA_W{1'b0}}  : read_exp(elem);

endmodule

// File: tb/tb_mem_march_bist.sv
// Bench for mem_march_bist: fault-injecting 1-cycle memory, plus 2-cycle memories for latency checks.
module tb_mem_march_bist;
  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_bc = 1'b0;

  logic       busy_a, done_a, fail_a, busy_b, done_b, fail_b, busy_c, done_c, fail_c;
  logic [3:0] fail_addr_a, fail_addr_b, fail_addr_c;
  logic [2:0] fail_elem_a, fail_elem_b, fail_elem_c;
  logic [7:0] fail_cnt_a, fail_cnt_b, fail_cnt_c;

  mem_march_bist_if #(.ADDR_W(4), .DATA_W(8)) bus_a ();
  mem_march_bist_if #(.ADDR_W(4), .DATA_W(8)) bus_b ();
  mem_march_bist_if #(.ADDR_W(4), .DATA_W(8)) bus_c ();

  mem_march_bist #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .fail(fail_a),
    .fail_addr(fail_addr_a), .fail_elem(fail_elem_a), .fail_cnt(fail_cnt_a), .mem(bus_a));
  mem_march_bist #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_bc), .busy(busy_b), .done(done_b), .fail(fail_b),
    .fail_addr(fail_addr_b), .fail_elem(fail_elem_b), .fail_cnt(fail_cnt_b), .mem(bus_b));
  mem_march_bist #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_bc), .busy(busy_c), .done(done_c), .fail(fail_c),
    .fail_addr(fail_addr_c), .fail_elem(fail_elem_c), .fail_cnt(fail_cnt_c), .mem(bus_c));

  int n_tests = 0;
  int n_fail  = 0;

  // Stuck-at fault on one bit of one word of memory A
  bit fault_en  = 1'b0;
  int fault_adr = 0;
  int fault_bit = 0;
  bit fault_val = 1'b0;

  function automatic logic [7:0] apply_fault(input logic [7:0] v, input logic [3:0] a);
    logic [7:0] r;
    r = v;
    if (fault_en && int'(a) == fault_adr) r[fault_bit] = fault_val;
    return r;
  endfunction

  logic [7:0] mem_a [N];
  logic [7:0] mem_b [N];
  logic [7:0] mem_c [N];
  logic [7:0] s1_b, s1_c;

  always @(posedge clk) begin
    if (bus_a.we) mem_a[bus_a.add] <= apply_fault(bus_a.data_in, bus_a.add);
    bus_a.data_out <= apply_fault(mem_a[bus_a.add], bus_a.add);
  end

  always @(posedge clk) begin
    if (bus_b.we) mem_b[bus_b.add] <= bus_b.data_in;
    s1_b           <= mem_b[bus_b.add];
    bus_b.data_out <= s1_b;
    if (bus_c.we) mem_c[bus_c.add] <= bus_c.data_in;
    s1_c           <= mem_c[bus_c.add];
    bus_c.data_out <= s1_c;
  end

  // Expected per-cycle bus activity of a whole run
  logic [3:0] q_add [$];
  logic       q_we  [$];
  logic [7:0] q_din [$];

  function automatic void build_trace(input int lat);
    int a;
    q_add.delete(); q_we.delete(); q_din.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? N - 1 - i : i;
        if (e != 0) begin
          for (int k = 0; k < lat + 1; k++) begin
            q_add.push_back(4'(a)); q_we.push_back(1'b0);
            q_din.push_back((e == 2 || e == 4) ? 8'hFF : 8'h00);
          end
        end
        if (e != 5) begin
          q_add.push_back(4'(a)); q_we.push_back(1'b1);
          q_din.push_back((e == 1 || e == 3) ? 8'hFF : 8'h00);
        end
      end
    end
  endfunction

  // Abstract March C- run over an array with the configured stuck-at fault
  function automatic void march_ref(output bit f, output int fa, output int fe, output int cnt);
    logic [7:0] m [N];
    logic [7:0] v, ex;
    int a;
    f = 1'b0; fa = 0; fe = 0; cnt = 0;
    for (int i = 0; i < N; i++) m[i] = 8'h00;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? N - 1 - i : i;
        if (e != 0) begin
          ex = (e == 2 || e == 4) ? 8'hFF : 8'h00;
          v  = apply_fault(m[a], 4'(a));
          if (v !== ex) begin
            if (!f) begin fa = a; fe = e; end
            f = 1'b1;
            cnt++;
          end
        end
        if (e != 5) m[a] = apply_fault((e == 1 || e == 3) ? 8'hFF : 8'h00, 4'(a));
      end
    end
  endfunction

  // Called at the negedge of run cycle 1; returns at the first idle negedge.
  task automatic wait_a(input int repulse_at, output int cycles, output int terr);
    cycles = 0; terr = 0;
    while (busy_a === 1'b1 && cycles < 2000) begin
      if (cycles < q_add.size()) begin
        if (bus_a.add !== q_add[cycles] || bus_a.we !== q_we[cycles] ||
            bus_a.data_in !== q_din[cycles]) terr++;
      end else begin
        terr++;
      end
      start_a = (cycles == repulse_at);
      cycles++;
      @(negedge clk);
    end
    start_a = 1'b0;
  endtask

  task automatic pulse_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b0; start_bc = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy_a, done_a, fail_a} !== 3'b000) begin
      n_fail++; $display("FAIL reset_status: got %b want 000", {busy_a, done_a, fail_a});
    end
    n_tests++;
    if ({bus_a.we, bus_a.add, bus_a.data_in} !== 13'h0) begin
      n_fail++; $display("FAIL reset_bus: got we=%b add=%0h din=%0h want 0", bus_a.we, bus_a.add, bus_a.data_in);
    end
    n_tests++;
    if ({fail_addr_a, fail_elem_a, fail_cnt_a} !== 15'h0) begin
      n_fail++; $display("FAIL reset_diag: got addr=%0d elem=%0d cnt=%0d want 0", fail_addr_a, fail_elem_a, fail_cnt_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fault_free();
    int cyc, terr;
    fault_en = 1'b0;
    build_trace(1);
    pulse_a();
    wait_a(-1, cyc, terr);
    n_tests++;
    if (cyc !== 240) begin n_fail++; $display("FAIL ff_length: got %0d want 240", cyc); end
    n_tests++;
    if (terr !== 0) begin n_fail++; $display("FAIL ff_trace: got %0d bad cycles want 0", terr); end
    n_tests++;
    if ({done_a, fail_a, fail_cnt_a} !== {1'b1, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL ff_result: got done=%b fail=%b cnt=%0d want 1 0 0", done_a, fail_a, fail_cnt_a);
    end
  endtask

  task automatic test_stuck_at();
    int cyc, terr;
    fault_en = 1'b1; fault_adr = 5; fault_bit = 3; fault_val = 1'b0;
    pulse_a();
    wait_a(-1, cyc, terr);
    n_tests++;
    if ({done_a, fail_a} !== 2'b11) begin n_fail++; $display("FAIL sa0_flags: got %b%b want 11", done_a, fail_a); end
    n_tests++;
    if (fail_addr_a !== 4'd5 || fail_elem_a !== 3'd2) begin
      n_fail++; $display("FAIL sa0_first: got addr=%0d elem=%0d want 5 2", fail_addr_a, fail_elem_a);
    end
    n_tests++;
    if (fail_cnt_a !== 8'd2) begin n_fail++; $display("FAIL sa0_cnt: got %0d want 2", fail_cnt_a); end
    n_tests++;
    if (cyc !== 240) begin n_fail++; $display("FAIL sa0_length: got %0d want 240", cyc); end
  endtask

  task automatic test_random_faults();
    int cyc, terr, fa, fe, cnt;
    bit f;
    for (int it = 0; it < 6; it++) begin
      fault_en  = 1'b1;
      fault_adr = int'($urandom_range(0, N - 1));
      fault_bit = int'($urandom_range(0, 7));
      fault_val = 1'($urandom_range(0, 1));
      march_ref(f, fa, fe, cnt);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pulse_a();
      wait_a(-1, cyc, terr);
      n_tests++;
      if (fail_a !== f || fail_cnt_a !== 8'(cnt) || fail_addr_a !== 4'(fa) || fail_elem_a !== 3'(fe) || terr !== 0) begin
        n_fail++;
        $display("FAIL rand_fault[%0d]: got fail=%b cnt=%0d addr=%0d elem=%0d trace=%0d want %b %0d %0d %0d 0",
                 it, fail_a, fail_cnt_a, fail_addr_a, fail_elem_a, terr, f, cnt, fa, fe);
      end
    end
  endtask

  task automatic test_restart();
    int cyc, terr;
    fault_en = 1'b1; fault_adr = 9; fault_bit = int'($urandom_range(0, 7)); fault_val = 1'b1;
    pulse_a();
    wait_a(49, cyc, terr);
    n_tests++;
    if (cyc !== 240 || terr !== 0) begin
      n_fail++; $display("FAIL busy_start_ignored: got len=%0d trace=%0d want 240 0", cyc, terr);
    end
    fault_en = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy_a, done_a, fail_a} !== 3'b100 || {fail_addr_a, fail_elem_a, fail_cnt_a} !== 15'h0) begin
      n_fail++; $display("FAIL restart_clear: got busy=%b done=%b fail=%b addr=%0d elem=%0d cnt=%0d want 1 0 0 0 0 0",
                         busy_a, done_a, fail_a, fail_addr_a, fail_elem_a, fail_cnt_a);
    end
    wait_a(-1, cyc, terr);
    n_tests++;
    if (cyc !== 240 || done_a !== 1'b1 || fail_a !== 1'b0) begin
      n_fail++; $display("FAIL restart_run: got len=%0d done=%b fail=%b want 240 1 0", cyc, done_a, fail_a);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, terr;
    fault_en = 1'b1; fault_adr = 2; fault_bit = 0; fault_val = 1'b1;
    pulse_a();
    start_a = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if ({busy_a, done_a, fail_a, bus_a.we, bus_a.add, bus_a.data_in, fail_addr_a, fail_elem_a, fail_cnt_a} !== 32'h0) begin
      n_fail++; $display("FAIL midrun_reset: got busy=%b done=%b fail=%b we=%b add=%0d din=%0h cnt=%0d want all 0",
                         busy_a, done_a, fail_a, bus_a.we, bus_a.add, bus_a.data_in, fail_cnt_a);
    end
    fault_en = 1'b0;
    pulse_a();
    wait_a(-1, cyc, terr);
    n_tests++;
    if (cyc !== 240 || terr !== 0 || done_a !== 1'b1 || fail_a !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_run: got len=%0d trace=%0d done=%b fail=%b want 240 0 1 0", cyc, terr, done_a, fail_a);
    end
  endtask

  task automatic test_latency();
    int cb, cc, cyc, terr;
    build_trace(2);
    cb = 0; cc = 0; cyc = 0; terr = 0;
    @(negedge clk) start_bc = 1'b1;
    @(negedge clk) start_bc = 1'b0;
    while ((busy_b === 1'b1 || busy_c === 1'b1) && cyc < 2000) begin
      if (busy_b === 1'b1) begin
        if (cb >= q_add.size() || bus_b.add !== q_add[cb] || bus_b.we !== q_we[cb] ||
            bus_b.data_in !== q_din[cb]) terr++;
        cb++;
      end
      if (busy_c === 1'b1) cc++;
      cyc++;
      @(negedge clk);
    end
    n_tests++;
    if (cb !== 320 || terr !== 0) begin n_fail++; $display("FAIL lat2_run: got len=%0d trace=%0d want 320 0", cb, terr); end
    n_tests++;
    if (done_b !== 1'b1 || fail_b !== 1'b0) begin n_fail++; $display("FAIL lat2_pass: got done=%b fail=%b want 1 0", done_b, fail_b); end
    n_tests++;
    if (cc !== 240 || done_c !== 1'b1 || fail_c !== 1'b1) begin
      n_fail++; $display("FAIL lat_mismatch: got len=%0d done=%b fail=%b want 240 1 1", cc, done_c, fail_c);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 8'($urandom); mem_b[i] = 8'($urandom); mem_c[i] = 8'($urandom);
    end
    test_reset();
    test_fault_free();
    test_stuck_at();
    test_random_faults();
    test_restart();
    test_reset_mid();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
